// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the Wishbone arbiters: grant-state encoding,
// default watchdog limit and the slave response bundle.
package wb_arb_pkg;

    // Grant state doubles as the one-hot grant vector presented on gnt_o.
    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StGnt0 = 2'b01,
        StGnt1 = 2'b10
    } arb_state_e;

    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;

    typedef struct packed {
        logic ack;
        logic err;
        logic rty;
    } wb_resp_t;

    localparam int unsigned RESP_WIDTH = $bits(wb_resp_t);

    function automatic int unsigned sel_width(input int unsigned data_width);
        return (data_width + 7) / 8;
    endfunction

endpackage

// File: rtl/wb_arb_watchdog.sv
// Stall counter for the arbiter: pulses timeout for one cycle once the owner's
// strobe has waited TIMEOUT_CYCLES cycles with no slave response.
module wb_arb_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] gnt,
    input  logic       active,
    input  logic       resp,
    output logic       timeout
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_eff;
    logic [1:0]       gnt_q;

    // A grant change discards any count left by the previous owner.
    always_comb begin
        cnt_eff = (gnt != gnt_q) ? '0 : cnt_q;
        timeout = active && !resp && (cnt_eff == LIMIT);
        cnt_d   = '0;
        if (active && !resp && !timeout) begin
            cnt_d = cnt_eff + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            gnt_q <= 2'b00;
        end else begin
            cnt_q <= cnt_d;
            gnt_q <= gnt;
        end
    end

endmodule

// File: rtl/wb_master_arbiter.sv
// Two-master round-robin Wishbone B3 classic arbiter with whole-burst bus lock.
// Define WB_ARB_TIMEOUT_EN to add the stall watchdog that errors hung cycles.
module wb_master_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned SELECT_WIDTH   = sel_width(DATA_WIDTH),
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic [ADDR_WIDTH-1:0]   m0_adr_i,
    input  logic [DATA_WIDTH-1:0]   m0_dat_i,
    output logic [DATA_WIDTH-1:0]   m0_dat_o,
    input  logic                    m0_we_i,
    input  logic [SELECT_WIDTH-1:0] m0_sel_i,
    input  logic                    m0_stb_i,
    input  logic                    m0_cyc_i,
    output logic                    m0_ack_o,
    output logic                    m0_err_o,
    output logic                    m0_rty_o,

    input  logic [ADDR_WIDTH-1:0]   m1_adr_i,
    input  logic [DATA_WIDTH-1:0]   m1_dat_i,
    output logic [DATA_WIDTH-1:0]   m1_dat_o,
    input  logic                    m1_we_i,
    input  logic [SELECT_WIDTH-1:0] m1_sel_i,
    input  logic                    m1_stb_i,
    input  logic                    m1_cyc_i,
    output logic                    m1_ack_o,
    output logic                    m1_err_o,
    output logic                    m1_rty_o,

    output logic [ADDR_WIDTH-1:0]   wbs_adr_o,
    output logic [DATA_WIDTH-1:0]   wbs_dat_o,
    input  logic [DATA_WIDTH-1:0]   wbs_dat_i,
    output logic                    wbs_we_o,
    output logic [SELECT_WIDTH-1:0] wbs_sel_o,
    output logic                    wbs_stb_o,
    output logic                    wbs_cyc_o,
    input  logic                    wbs_ack_i,
    input  logic                    wbs_err_i,
    input  logic                    wbs_rty_i,

    output logic [1:0]              gnt_o
);

    arb_state_e state;
    logic       last;  // 1: m1 owned most recently, 0: m0
    logic       own0;
    logic       own1;
    logic       owner_stb;
    logic       owner_cyc;
    logic       wd_timeout;
    wb_resp_t   slv_resp;

    // Grant FSM; the state register is itself the registered one-hot grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= StIdle;
            last  <= 1'b1;
        end else begin
            case (state)
                StIdle: begin
                    if (m0_cyc_i && m1_cyc_i) begin
                        if (last) begin
                            state <= StGnt0;
                            last  <= 1'b0;
                        end else begin
                            state <= StGnt1;
                            last  <= 1'b1;
                        end
                    end else if (m0_cyc_i) begin
                        state <= StGnt0;
                        last  <= 1'b0;
                    end else if (m1_cyc_i) begin
                        state <= StGnt1;
                        last  <= 1'b1;
                    end
                end
                StGnt0: begin
                    if (!m0_cyc_i) begin
                        if (m1_cyc_i) begin
                            state <= StGnt1;
                            last  <= 1'b1;
                        end else begin
                            state <= StIdle;
                        end
                    end
                end
                StGnt1: begin
                    if (!m1_cyc_i) begin
                        if (m0_cyc_i) begin
                            state <= StGnt0;
                            last  <= 1'b0;
                        end else begin
                            state <= StIdle;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign own0  = (state == StGnt0);
    assign own1  = (state == StGnt1);
    assign gnt_o = state;

    always_comb begin
        wbs_adr_o = '0;
        wbs_dat_o = '0;
        wbs_we_o  = 1'b0;
        wbs_sel_o = '0;
        owner_stb = 1'b0;
        owner_cyc = 1'b0;
        case (state)
            StGnt0: begin
                wbs_adr_o = m0_adr_i;
                wbs_dat_o = m0_dat_i;
                wbs_we_o  = m0_we_i;
                wbs_sel_o = m0_sel_i;
                owner_stb = m0_stb_i;
                owner_cyc = m0_cyc_i;
            end
            StGnt1: begin
                wbs_adr_o = m1_adr_i;
                wbs_dat_o = m1_dat_i;
                wbs_we_o  = m1_we_i;
                wbs_sel_o = m1_sel_i;
                owner_stb = m1_stb_i;
                owner_cyc = m1_cyc_i;
            end
            default: ;
        endcase
    end

    assign wbs_cyc_o = owner_cyc;
    assign wbs_stb_o = owner_stb && owner_cyc && !wd_timeout;

    assign slv_resp.ack = wbs_ack_i;
    assign slv_resp.err = wbs_err_i;
    assign slv_resp.rty = wbs_rty_i;

`ifdef WB_ARB_TIMEOUT_EN
    wb_arb_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .gnt     (gnt_o),
        .active  (owner_stb && owner_cyc),
        .resp    (|slv_resp),
        .timeout (wd_timeout)
    );
`else
    assign wd_timeout = 1'b0;
`endif

    // Routing keys off the registered grant, so an ack arriving as the owner
    // drops cyc still reaches it.
    assign m0_ack_o = own0 && slv_resp.ack;
    assign m0_err_o = own0 && (slv_resp.err || wd_timeout);
    assign m0_rty_o = own0 && slv_resp.rty;
    assign m1_ack_o = own1 && slv_resp.ack;
    assign m1_err_o = own1 && (slv_resp.err || wd_timeout);
    assign m1_rty_o = own1 && slv_resp.rty;

    assign m0_dat_o = wbs_dat_i;
    assign m1_dat_o = wbs_dat_i;

endmodule
